// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: each transaction runs IDLE -> ACCESS -> RESP,
// illegal requests are answered with err. Define DMEM_ARB_RR_EN for round-robin arbitration.
module dmem_arbiter #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [2:0]  m0_func3,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [2:0]  m1_func3,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  func3,
  output logic [31:0] addr,
  output logic [31:0] w_data,
  input  logic [31:0] r_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [2:0]  func3_q, func3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
`ifdef DMEM_ARB_RR_EN
  logic        ptr_q, ptr_d;
`endif

  logic        prefer_m1, win_m1, grant;
  logic        func_ok, misaligned, legal, resp_live;
  logic [32:0] size_m1, last_byte;

  // Legality of the latched request; the 33-bit sum keeps addresses near 2^32 from wrapping into range.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    size_m1 = 33'd3;
    case (func3_q[1:0])
      2'd0:    size_m1 = 33'd0;
      2'd1:    size_m1 = 33'd1;
      default: size_m1 = 33'd3;
    endcase
    if (we_q) func_ok = func3_q inside {3'd0, 3'd1, 3'd2};
    else      func_ok = func3_q inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    misaligned = ((func3_q[1:0] == 2'd1) && addr_q[0]) ||
                 ((func3_q == 3'd2) && (addr_q[1:0] != 2'b00));
    last_byte  = {1'b0, addr_q} + size_m1;
    legal      = func_ok && !misaligned && (last_byte < 33'(DEPTH));
  end

  always_comb begin
`ifdef DMEM_ARB_RR_EN
    prefer_m1 = ptr_q;
`else
    prefer_m1 = 1'b0;
`endif
    win_m1 = m1_req && (!m0_req || prefer_m1);
    grant  = rst_n && (state_q == IDLE) && (m0_req || m1_req);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    we_d    = we_q;
    func3_d = func3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef DMEM_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    if (grant) begin
      owner_d = win_m1;
      we_d    = win_m1 ? m1_we    : m0_we;
      func3_d = win_m1 ? m1_func3 : m0_func3;
      addr_d  = win_m1 ? m1_addr  : m0_addr;
      wdata_d = win_m1 ? m1_wdata : m0_wdata;
`ifdef DMEM_ARB_RR_EN
      ptr_d   = !win_m1;
`endif
    end
    if (state_q == ACCESS) begin
      rdata_d = (legal && !we_q) ? r_data : 32'h0;
      err_d   = !legal;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      func3_q <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      owner_q <= owner_d;
      we_q    <= we_d;
      func3_q <= func3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef DMEM_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Responses are gated by rst_n so a reset during RESP never produces an rvalid.
  always_comb begin
    m0_gnt    = grant && !win_m1;
    m1_gnt    = grant && win_m1;
    MemRead   = (state_q == ACCESS) && legal && !we_q;
    MemWrite  = (state_q == ACCESS) && legal && we_q;
    func3     = func3_q;
    addr      = addr_q;
    w_data    = wdata_q;
    resp_live = rst_n && (state_q == RESP);
    m0_rvalid = resp_live && !owner_q;
    m1_rvalid = resp_live && owner_q;
    m0_err    = m0_rvalid && err_q;
    m1_err    = m1_rvalid && err_q;
    m0_rdata  = m0_rvalid ? rdata_q : 32'h0;
    m1_rdata  = m1_rvalid ? rdata_q : 32'h0;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: DEPTH, 256, data memory size in bytes; addresses >= DEPTH are out of range.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 Ports per requester k in {0,1}: mk_req in 1 request; mk_we in 1 write (1) / read (0); mk_func3 in 3 access size code; mk_addr in 32 byte address; mk_wdata in 32 store data.
REQ-005 Ports per requester k: mk_gnt out 1 accept pulse; mk_rvalid out 1 response pulse; mk_err out 1 error flag, valid with mk_rvalid; mk_rdata out 32 load data, valid with mk_rvalid.
REQ-006 Memory-side ports: MemRead out 1; MemWrite out 1; func3 out 3; addr out 32; w_data out 32; r_data in 32 (combinational read data from memory).

Function
REQ-007 FSM states: IDLE, ACCESS, RESP; state and owner are registered.
REQ-008 IDLE: if either mk_req=1, select one winner, pulse its mk_gnt for that cycle, latch we/func3/addr/wdata/owner, and go to ACCESS; otherwise stay in IDLE.
REQ-009 mk_gnt is combinational, asserted only in IDLE, and asserted for at most one requester per cycle.
REQ-010 Requesters hold req and payload stable until gnt; payload after the gnt cycle is ignored.
REQ-011 ACCESS, legal request: drive memory from latched fields for exactly one cycle (MemRead=~we, MemWrite=we); capture r_data into the response register at the clock edge that ends the cycle; go to RESP.
REQ-012 RESP: owner's mk_rvalid=1 for exactly one cycle with mk_rdata and mk_err; return to IDLE. Fixed latency is gnt cycle + 2 cycles to rvalid; at most one transaction per 3 cycles.
REQ-013 Legal func3 values: reads accept 0, 1, 2, 4, 5; writes accept 0, 1, 2. Any other value is illegal.
REQ-014 Misaligned requests are illegal: func3 in {1,5} with addr[0]=1, or func3=2 with addr[1:0]!=0.
REQ-015 Out-of-range requests are illegal: addr+size-1 >= DEPTH, where size is 1, 2 or 4 bytes.
REQ-016 Illegal request: MemRead and MemWrite stay 0 in ACCESS, the response has mk_err=1 and mk_rdata=0, and latency is unchanged.
REQ-017 Outside ACCESS: MemRead=MemWrite=0, and addr, w_data and func3 hold their latched values.
REQ-018 A read response carries r_data unmodified; sign/zero extension is done by the memory per func3.
REQ-019 Requests arriving in ACCESS or RESP are not granted; they are evaluated in the next IDLE cycle.
REQ-020 The non-owner's rvalid, err and rdata outputs are 0.

Reset
REQ-021 With rst_n=0 at a rising edge: state=IDLE, owner=0, priority pointer=0 (m0 preferred), response register=0, latched fields=0.
REQ-022 During and after reset, all gnt/rvalid/err outputs and MemRead/MemWrite are 0 until a new grant occurs.
REQ-023 Reset in ACCESS or RESP aborts the transaction: no rvalid is issued. If the reset edge ends the ACCESS cycle, that cycle's write has already been presented to memory and still completes.

Configuration
REQ-024 Macro DMEM_ARB_RR_EN defined: round-robin arbitration. The priority pointer flips to the non-winner on every grant, so with both requesting continuously, grants alternate m0, m1, m0, ...
REQ-025 Macro DMEM_ARB_RR_EN undefined: fixed priority, m0 always wins. There is no pointer register; m1 is granted only when m0_req=0 in IDLE.

Verification
REQ-026 Memory preloaded mem[i]=i+20; m0 read func3=2 addr=0 -> m0_gnt at T, MemRead at T+1, m0_rvalid at T+2 with rdata=0x17161514, err=0.
REQ-027 m1 write func3=1 addr=0x10 wdata=0xBEEF, then m1 read func3=5 addr=0x10 -> rdata=0x0000BEEF; then read func3=1 addr=0x10 -> memory returns 0xFFFFBEEF.
REQ-028 m0 read func3=2 addr=0x02 -> MemRead stays 0 throughout, rvalid at T+2 with err=1, rdata=0; m0 write func3=4 addr=0 -> err=1, MemWrite never asserted; read func3=2 addr=0xFE (DEPTH=256) -> err=1.
REQ-029 m0_req and m1_req held high from reset for 4 grants -> with DMEM_ARB_RR_EN grant order is m0, m1, m0, m1 at 3-cycle spacing; without it, m0 receives all 4.
REQ-030 rst_n=0 for one edge while in RESP -> no rvalid on either port, state IDLE; a subsequent m1 read completes normally with 2-cycle latency.
